// File: rtl/lif_neuron_if.sv
// Signal bundle between a leaky integrate-and-fire neuron and whatever drives it:
// input spike, weight, threshold and enable in; fire pulse and observed state out.
interface lif_neuron_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic             spike_in;
    logic [WIDTH-1:0] weight;
    logic [WIDTH-1:0] threshold;
    logic             spike_out;
    logic [WIDTH-1:0] membrane;
    logic             refractory;
    logic [7:0]       spike_count;

    modport master (
        output ena, spike_in, weight, threshold,
        input  spike_out, membrane, refractory, spike_count
    );

    modport slave (
        input  ena, spike_in, weight, threshold,
        output spike_out, membrane, refractory, spike_count
    );
endinterface

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates weighted input spikes into a leaking
// membrane potential, fires a one-cycle pulse at threshold, then blanks its input.
module lif_neuron #(
    parameter int WIDTH             = 8,
    parameter int LEAK_SHIFT        = 3,
    parameter int REFRACTORY_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    lif_neuron_if.slave   bus
);
    localparam int CW = (REFRACTORY_CYCLES < 2) ? 1 : $clog2(REFRACTORY_CYCLES + 1);

    typedef enum logic {
        INTEGRATE = 1'b0,
        REFRACT   = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] membrane_q;
    logic             spike_out_q;
    logic             refractory_q;
    logic [CW-1:0]    counter;
    logic [7:0]       spike_count_q;

    logic [WIDTH-1:0] leak;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] v_next;
    logic             fire;

    // The leak can never exceed the membrane, so the extra bit only ever catches overflow.
    always_comb begin
        leak   = membrane_q >> LEAK_SHIFT;
        sum    = {1'b0, membrane_q} - {1'b0, leak}
               + (bus.spike_in ? {1'b0, bus.weight} : {(WIDTH + 1){1'b0}});
        v_next = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        fire   = (v_next >= bus.threshold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= INTEGRATE;
            membrane_q    <= '0;
            spike_out_q   <= 1'b0;
            refractory_q  <= 1'b0;
            counter       <= '0;
            spike_count_q <= '0;
        end else if (!bus.ena) begin
            spike_out_q <= 1'b0;
        end else begin
            case (state)
                INTEGRATE: begin
                    if (fire) begin
                        membrane_q    <= '0;
                        spike_out_q   <= 1'b1;
                        spike_count_q <= spike_count_q + 8'd1;
                        if (REFRACTORY_CYCLES > 0) begin
                            state        <= REFRACT;
                            refractory_q <= 1'b1;
                            counter      <= CW'(REFRACTORY_CYCLES);
                        end
                    end else begin
                        membrane_q  <= v_next;
                        spike_out_q <= 1'b0;
                    end
                end
                REFRACT: begin
                    membrane_q  <= '0;
                    spike_out_q <= 1'b0;
                    if (counter == CW'(1)) begin
                        counter      <= '0;
                        state        <= INTEGRATE;
                        refractory_q <= 1'b0;
                    end else begin
                        counter <= counter - CW'(1);
                    end
                end
                default: begin
                    state        <= INTEGRATE;
                    refractory_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.membrane    = membrane_q;
    assign bus.spike_out   = spike_out_q;
    assign bus.refractory  = refractory_q;
    assign bus.spike_count = spike_count_q;
endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: one instance with a 4-cycle refractory period and one with
// none, driven from a vector table plus hand-written corner-case sequences.
module tb_lif_neuron;
    logic clk;
    logic rst_n;

    lif_neuron_if #(.WIDTH(8)) bus_a ();
    lif_neuron_if #(.WIDTH(8)) bus_b ();

    lif_neuron #(.WIDTH(8), .LEAK_SHIFT(3), .REFRACTORY_CYCLES(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    lif_neuron #(.WIDTH(8), .LEAK_SHIFT(3), .REFRACTORY_CYCLES(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       reset_first;
        logic       ena;
        logic       spike_in;
        logic [7:0] weight;
        logic [7:0] threshold;
        logic [7:0] exp_membrane;
        logic       exp_spike;
        logic       exp_refr;
        logic [7:0] exp_count;
    } vec_t;

    typedef struct {
        logic [7:0] membrane;
        logic       spike;
        logic       refr;
        logic [7:0] count;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Pops the oldest expectation and compares it against the selected instance.
    task automatic checkOutput(input int sel);
        exp_t       e;
        logic [7:0] m;
        logic       s;
        logic       r;
        logic [7:0] c;
        if (sel == 0) begin
            m = bus_a.membrane; s = bus_a.spike_out; r = bus_a.refractory; c = bus_a.spike_count;
        end else begin
            m = bus_b.membrane; s = bus_b.spike_out; r = bus_b.refractory; c = bus_b.spike_count;
        end
        compared++;
        if (sb_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_empty: got output with no expectation queued");
            return;
        end
        e = sb_q.pop_front();
        if (m !== e.membrane || s !== e.spike || r !== e.refr || c !== e.count) begin
            mismatched++;
            $display("[TB] FAIL %s: got membrane=%0d spike=%b refr=%b count=%0d, want membrane=%0d spike=%b refr=%b count=%0d",
                     e.name, m, s, r, c, e.membrane, e.spike, e.refr, e.count);
        end
    endtask

    task automatic pushExp(input vec_t v, input string name);
        exp_t e;
        e.membrane = v.exp_membrane;
        e.spike    = v.exp_spike;
        e.refr     = v.exp_refr;
        e.count    = v.exp_count;
        e.name     = name;
        sb_q.push_back(e);
    endtask

    // Called at posedge+1: drives inputs, queues the expectation, checks after the next edge.
    task automatic applyStimulus(input int sel, input vec_t v, input string name);
        if (sel == 0) begin
            bus_a.ena = v.ena; bus_a.spike_in = v.spike_in;
            bus_a.weight = v.weight; bus_a.threshold = v.threshold;
        end else begin
            bus_b.ena = v.ena; bus_b.spike_in = v.spike_in;
            bus_b.weight = v.weight; bus_b.threshold = v.threshold;
        end
        pushExp(v, name);
        @(posedge clk);
        #1;
        checkOutput(sel);
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic en, input logic si, input logic [7:0] w,
                                input logic [7:0] th, input logic [7:0] em, input logic es,
                                input logic er, input logic [7:0] ec);
        vec_t v;
        v.reset_first = 1'b0; v.ena = en; v.spike_in = si; v.weight = w; v.threshold = th;
        v.exp_membrane = em; v.exp_spike = es; v.exp_refr = er; v.exp_count = ec;
        return v;
    endfunction

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t tbl[19];
        vec_t v;
        logic [7:0] model_m;
        logic [7:0] model_c;

        tbl[0]  = mk(1, 1,  40, 100,  40, 0, 0, 0);
        tbl[1]  = mk(1, 1,  40, 100,  75, 0, 0, 0);
        tbl[2]  = mk(1, 1,  40, 100,   0, 1, 1, 1);
        tbl[3]  = mk(1, 1,  40, 100,   0, 0, 1, 1);
        tbl[4]  = mk(1, 1,  40, 100,   0, 0, 1, 1);
        tbl[5]  = mk(1, 1,  40, 100,   0, 0, 1, 1);
        tbl[6]  = mk(1, 1,  40, 100,   0, 0, 0, 1);
        tbl[7]  = mk(1, 1,  40, 100,  40, 0, 0, 1);
        tbl[8]  = mk(1, 1, 200, 255, 200, 0, 0, 0);
        tbl[8].reset_first = 1'b1;
        tbl[9]  = mk(1, 1, 200, 255,   0, 1, 1, 1);
        tbl[10] = mk(1, 0, 200, 255,   0, 0, 1, 1);
        tbl[11] = mk(1, 0, 200, 255,   0, 0, 1, 1);
        tbl[12] = mk(1, 0, 200, 255,   0, 0, 1, 1);
        tbl[13] = mk(1, 0, 200, 255,   0, 0, 0, 1);
        tbl[14] = mk(1, 1, 200, 255, 200, 0, 0, 1);
        tbl[15] = mk(1, 0, 200, 255, 175, 0, 0, 1);
        tbl[16] = mk(1, 0, 200, 255, 154, 0, 0, 1);
        tbl[17] = mk(1, 0, 200, 255, 135, 0, 0, 1);
        tbl[18] = mk(1, 0, 200, 255, 119, 0, 0, 1);

        bus_a.ena = 1'b1; bus_a.spike_in = 1'b1; bus_a.weight = 8'd40; bus_a.threshold = 8'd100;
        bus_b.ena = 1'b0; bus_b.spike_in = 1'b0; bus_b.weight = 8'd0;  bus_b.threshold = 8'd0;
        rst_n = 1'b0;

        // Reset held across edges with spikes present
        repeat (3) @(posedge clk);
        #1;
        pushExp(mk(1, 1, 40, 100, 0, 0, 0, 0), "reset_hold_a");
        checkOutput(0);
        pushExp(mk(0, 0, 0, 0, 0, 0, 0, 0), "reset_hold_b");
        checkOutput(1);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            if (tbl[i].reset_first) pulseReset();
            applyStimulus(0, tbl[i], $sformatf("table_%0d", i));
        end

        // Leak continues down to 7 and then stops decaying
        model_m = 8'd119;
        for (int i = 0; i < 30; i++) begin
            model_m = model_m - (model_m >> 3);
            applyStimulus(0, mk(1, 0, 200, 255, model_m, 0, 0, 1), $sformatf("decay_%0d", i));
        end
        pushExp(mk(1, 0, 200, 255, 7, 0, 0, 1), "decay_floor");
        checkOutput(0);

        // Enable gating in the middle of a refractory period
        applyStimulus(0, mk(1, 1, 255, 200, 0, 1, 1, 2), "sat_fire");
        applyStimulus(0, mk(1, 1, 255, 200, 0, 0, 1, 2), "refr_cnt3");
        applyStimulus(0, mk(1, 1, 255, 200, 0, 0, 1, 2), "refr_cnt2");
        for (int i = 0; i < 5; i++)
            applyStimulus(0, mk(0, 1, 255, 200, 0, 0, 1, 2), $sformatf("ena_low_%0d", i));
        applyStimulus(0, mk(1, 1, 255, 200, 0, 0, 1, 2), "refr_cnt1");
        applyStimulus(0, mk(1, 1, 255, 200, 0, 0, 0, 2), "refr_exit");
        applyStimulus(0, mk(1, 1, 255, 200, 0, 1, 1, 3), "refire");
        applyStimulus(0, mk(0, 1, 255, 200, 0, 0, 1, 3), "ena_low_clears_spike");

        // Asynchronous reset between edges while refractory
        #2;
        rst_n = 1'b0;
        #1;
        pushExp(mk(0, 0, 0, 0, 0, 0, 0, 0), "async_reset_mid_refract");
        checkOutput(0);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, mk(1, 1, 40, 100, 40, 0, 0, 0), "post_reset_integrate");

        // Gated integrate cycle holds membrane
        applyStimulus(0, mk(0, 1, 40, 100, 40, 0, 0, 0), "ena_low_hold_membrane");

        // No refractory period: fires every cycle and the count wraps
        model_c = 8'd0;
        for (int i = 0; i < 256; i++) begin
            model_c = model_c + 8'd1;
            applyStimulus(1, mk(1, 0, 0, 0, 0, 1, 0, model_c), $sformatf("wrap_%0d", i));
        end
        applyStimulus(1, mk(0, 0, 0, 0, 0, 0, 0, 0), "wrap_final_zero");

        if (sb_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_leftover: %0d expectations never compared", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
Leaky integrate-and-fire neuron that sits directly downstream of a synapse. It consumes the synapse's spike_output as its spike_in and adds a programmable weight to a membrane potential that leaks every enabled cycle. When the potential reaches a threshold, the neuron emits a one-cycle output spike, clears the potential and enters a refractory period. Its spike_out drives the next synapse's spike_input in the oscillator network.

Parameters:
WIDTH, 8, membrane/weight/threshold width in bits
LEAK_SHIFT, 3, leak = membrane >> LEAK_SHIFT per enabled cycle
REFRACTORY_CYCLES, 4, enabled cycles of input blanking after a fire (0 = none)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  clock enable; when 0 all state holds
spike_in  input  1  spike from upstream synapse, sampled each enabled cycle
weight  input  WIDTH  unsigned increment applied per input spike
threshold  input  WIDTH  unsigned fire threshold
spike_out  output  1  registered one-cycle fire pulse
membrane  output  WIDTH  current membrane potential (registered)
refractory  output  1  high while in REFRACT state
spike_count  output  8  count of fires, wraps 255->0

Behaviour:
- Reset (async, rst_n=0): state=INTEGRATE, membrane=0, spike_out=0, refractory=0, refractory counter=0, spike_count=0. Takes effect immediately, mid-operation included.
- ena=0: membrane, state, counter and spike_count hold; spike_out is 0 at the next edge.
- States: INTEGRATE, REFRACT. refractory = (state==REFRACT).
- INTEGRATE, per enabled edge:
  - v_next = membrane - (membrane >> LEAK_SHIFT) + (spike_in ? weight : 0).
  - Computed in WIDTH+1 bits, saturated to 2^WIDTH-1.
  - Leak is 0 when membrane < 2^LEAK_SHIFT, so small values do not decay.
  - LEAK_SHIFT=0 fully clears the previous value each cycle.
  - If v_next >= threshold, fire:
    - membrane<=0, spike_out<=1, spike_count<=spike_count+1 (mod 256).
    - If REFRACTORY_CYCLES>0: state<=REFRACT, counter<=REFRACTORY_CYCLES; otherwise stay in INTEGRATE.
  - Else: membrane<=v_next, spike_out<=0.
  - threshold=0 fires on every enabled INTEGRATE cycle.
- REFRACT, per enabled edge:
  - spike_in ignored; membrane held at 0; spike_out<=0; counter decrements.
  - When counter==1 at the edge: counter<=0, state<=INTEGRATE.
  - REFRACT therefore lasts exactly REFRACTORY_CYCLES enabled cycles.
- Latency: the input spike sampled at edge N appears in membrane after edge N. The fire pulse is high for exactly the one cycle following edge N.
- spike_out is never high on two consecutive cycles when REFRACTORY_CYCLES>0.
- weight and threshold may change at any time; they are used combinationally at the sampling edge.

Test Plan:
- Reset: hold rst_n=0 with spike_in=1 -> membrane=0, spike_out=0, refractory=0, spike_count=0. Deassert -> integration starts at the first enabled edge.
- Integrate/fire (weight=40, threshold=100, spike_in=1 every cycle):
  - membrane 40, 75; third edge v_next=106 -> spike_out=1 for one cycle, membrane=0, spike_count=1, refractory=1.
  - Next 4 edges membrane stays 0 despite spikes; then refractory=0 and membrane 40 on the following edge.
- Leak only (weight=200, threshold=255, single spike then spike_in=0) -> membrane 200, 175, 154, 135, 119; no fire. Decay stops once membrane < 8.
- Saturation (weight=200, threshold=255, two consecutive spikes) -> second sum 375 saturates to 255 and fires; membrane=0, spike_count increments.
- ena gating: drop ena for 5 cycles during REFRACT with counter=2 -> counter, membrane and state hold, spike_out=0. After re-enable, exactly 2 more enabled cycles of refractory.
- Async reset mid-refractory and count wrap:
  - Assert rst_n=0 between edges during REFRACT -> refractory and spike_count clear immediately, without a clock edge.
  - With threshold=0 and REFRACTORY_CYCLES=0 -> fires every enabled cycle; spike_count reads 0 after 256 fires.
